// File: rtl/sim_frame_trigger_pkg.sv
// Shared types and widths for the simulation frame trigger and its helpers.
package sim_frame_pkg;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned WDOG_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DUMPING = 2'd2,
    ST_DONE    = 2'd3
  } frame_state_e;

endpackage

// File: rtl/sim_frame_trigger_if.sv
// Signal bundle between the harness (master) and sim_frame_trigger (slave).
interface sim_frame_trigger_if;
  import sim_frame_pkg::*;

  logic               vs;
  logic               downloading;
  logic [FRAME_W-1:0] frame_cnt;
  logic               vs_fall;
  logic               dump_on;
  logic               dump_start;
  logic               dump_stop;
  logic               dwnld_done;
  logic               vs_lost;

  modport master (
    output vs, downloading,
    input  frame_cnt, vs_fall, dump_on, dump_start, dump_stop, dwnld_done, vs_lost
  );

  modport slave (
    input  vs, downloading,
    output frame_cnt, vs_fall, dump_on, dump_start, dump_stop, dwnld_done, vs_lost
  );
endinterface

// File: rtl/sim_frame_trigger_vs_sync.sv
// sim_vs_sync: 2-FF synchroniser for an asynchronous level plus a falling-edge pulse.
module sim_vs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall = s3_q & ~s2_q;
endmodule

// File: rtl/sim_frame_trigger.sv
// Frame counter and dump-window strobes for the simulation dump controller.
// Optional VS watchdog built when FRAME_WDOG_EN is defined.
module sim_frame_trigger
  import sim_frame_pkg::*;
#(
  parameter logic [FRAME_W-1:0] START_FRAME = 32'd0,
  parameter logic [FRAME_W-1:0] STOP_FRAME  = 32'd0,
  parameter logic               WAIT_DWNLD  = 1'b0,
  parameter logic [WDOG_W-1:0]  WDOG_CLKS   = 24'd4_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  sim_frame_trigger_if.slave  bus
);
  localparam logic STOP_EN = (STOP_FRAME != '0) && (STOP_FRAME != START_FRAME);

  frame_state_e       state_q, state_d;
  logic [FRAME_W-1:0] frame_q;
  logic               dl_q;
  logic               start_q, stop_q;
  logic               start_d, stop_d;
  logic               vs_fall;
  logic               dl_rise, dl_fall, restart;

  sim_vs_sync u_vs_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.vs),
    .fall     (vs_fall)
  );

  assign dl_rise = bus.downloading & ~dl_q;
  assign dl_fall = dl_q & ~bus.downloading;
  assign restart = WAIT_DWNLD && dl_rise && (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dl_q    <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= bus.downloading;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  // A download restart overrides every other transition, including a pending open/close.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (!WAIT_DWNLD || dl_fall)           state_d = ST_ARMED;
        ST_ARMED:   if (frame_q == START_FRAME)           state_d = ST_DUMPING;
        ST_DUMPING: if (STOP_EN && frame_q == STOP_FRAME) state_d = ST_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    start_d = 1'b0;
    stop_d  = 1'b0;
    if (state_q == ST_ARMED && state_d == ST_DUMPING) start_d = 1'b1;
    if (state_q == ST_DUMPING && state_d != ST_DUMPING) stop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (restart) begin
      frame_q <= '0;
    end else if (vs_fall && state_q != ST_IDLE) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  assign bus.frame_cnt  = frame_q;
  assign bus.vs_fall    = vs_fall;
  assign bus.dump_on    = (state_q == ST_DUMPING);
  assign bus.dump_start = start_q;
  assign bus.dump_stop  = stop_q;
  assign bus.dwnld_done = dl_fall;

`ifdef FRAME_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              lost_q;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_IDLE || vs_fall) wdog_d = '0;
    else if (wdog_q != '1)             wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q <= '0;
      lost_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (state_q != ST_IDLE && wdog_d >= WDOG_CLKS) lost_q <= 1'b1;
    end
  end

  assign bus.vs_lost = lost_q;
`else
  assign bus.vs_lost = 1'b0;
`endif
endmodule

// File: tb/tb_sim_frame_trigger.sv
// Directed self-checking bench for sim_frame_trigger (four configurations side by side).
module tb_sim_frame_trigger;
  logic clk = 1'b0;
  logic rst_n;
  logic vs, dl_w, vs_w, wd_follow;
  int unsigned n_asrt = 0;
  int unsigned n_fail = 0;

`ifdef FRAME_WDOG_EN
  localparam logic WDOG_EXP = 1'b1;
`else
  localparam logic WDOG_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  sim_frame_trigger_if if_def ();
  sim_frame_trigger_if if_win ();
  sim_frame_trigger_if if_wait ();
  sim_frame_trigger_if if_wd ();

  assign if_def.vs           = vs;
  assign if_def.downloading  = 1'b0;
  assign if_win.vs           = vs;
  assign if_win.downloading  = 1'b0;
  assign if_wait.vs          = vs;
  assign if_wait.downloading = dl_w;
  assign if_wd.vs            = wd_follow ? vs : vs_w;
  assign if_wd.downloading   = 1'b0;

  sim_frame_trigger u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));

  sim_frame_trigger #(.START_FRAME(32'd3), .STOP_FRAME(32'd6)) u_win (
    .clk(clk), .rst_n(rst_n), .bus(if_win));

  sim_frame_trigger #(.WAIT_DWNLD(1'b1)) u_wait (
    .clk(clk), .rst_n(rst_n), .bus(if_wait));

  sim_frame_trigger #(.START_FRAME(32'd1000), .WDOG_CLKS(24'd100)) u_wd (
    .clk(clk), .rst_n(rst_n), .bus(if_wd));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pin fall -> vs_fall high after 2nd edge -> counter bumped at 3rd edge.
  task automatic fall3();
    vs = 1'b0;
    tick();
    tick();
    check("vs_fall_hi", 32'(if_def.vs_fall), 32'd1);
    tick();
    check("vs_fall_lo", 32'(if_def.vs_fall), 32'd0);
  endtask

  task automatic rest();
    repeat (5) tick();
    vs = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b1; dl_w = 1'b0; vs_w = 1'b1; wd_follow = 1'b0;
    repeat (3) tick();
    check("rst_frame_cnt",  if_def.frame_cnt, 32'd0);
    check("rst_dump_on",    32'(if_def.dump_on), 32'd0);
    check("rst_dump_start", 32'(if_def.dump_start), 32'd0);
    check("rst_vs_fall",    32'(if_def.vs_fall), 32'd0);
    check("rst_dwnld_done", 32'(if_wait.dwnld_done), 32'd0);
    check("rst_vs_lost",    32'(if_wd.vs_lost), 32'd0);

    rst_n = 1'b1; dl_w = 1'b1;
    tick();
    check("def_start_e1", 32'(if_def.dump_start), 32'd0);
    check("def_on_e1",    32'(if_def.dump_on), 32'd0);
    tick();
    check("def_start_e2", 32'(if_def.dump_start), 32'd1);
    check("def_on_e2",    32'(if_def.dump_on), 32'd1);
    tick();
    check("def_start_e3", 32'(if_def.dump_start), 32'd0);
    check("def_on_e3",    32'(if_def.dump_on), 32'd1);

    repeat (97) tick();
    check("wd_lost_e100", 32'(if_wd.vs_lost), 32'd0);
    tick();
    check("wd_lost_e101", 32'(if_wd.vs_lost), 32'(WDOG_EXP));
    wd_follow = 1'b1;

    fall3();
    check("def_cnt_f1", if_def.frame_cnt, 32'd1);
    check("win_cnt_f1", if_win.frame_cnt, 32'd1);
    check("win_on_f1",  32'(if_win.dump_on), 32'd0);
    rest();
    fall3();
    rest();
    fall3();
    check("win_cnt_f3",   if_win.frame_cnt, 32'd3);
    check("win_start_f3", 32'(if_win.dump_start), 32'd0);
    tick();
    check("win_start_hi", 32'(if_win.dump_start), 32'd1);
    check("win_on_open",  32'(if_win.dump_on), 32'd1);
    tick();
    check("win_start_lo", 32'(if_win.dump_start), 32'd0);
    check("win_on_hold",  32'(if_win.dump_on), 32'd1);
    rest();
    fall3();
    check("wait_cnt_dl", if_wait.frame_cnt, 32'd0);
    rest();
    fall3();
    check("def_cnt_f5", if_def.frame_cnt, 32'd5);
    check("def_on_f5",  32'(if_def.dump_on), 32'd1);
    check("def_stop_f5", 32'(if_def.dump_stop), 32'd0);
    rest();
    check("wd_lost_sticky", 32'(if_wd.vs_lost), 32'(WDOG_EXP));

    fall3();
    check("win_cnt_f6", if_win.frame_cnt, 32'd6);
    check("win_on_f6",  32'(if_win.dump_on), 32'd1);
    tick();
    check("win_stop_hi", 32'(if_win.dump_stop), 32'd1);
    check("win_on_shut", 32'(if_win.dump_on), 32'd0);
    tick();
    check("win_stop_lo", 32'(if_win.dump_stop), 32'd0);
    rest();
    fall3();
    check("win_cnt_f7", if_win.frame_cnt, 32'd7);
    check("win_on_done", 32'(if_win.dump_on), 32'd0);
    check("wait_cnt_f7", if_wait.frame_cnt, 32'd0);
    rest();

    dl_w = 1'b0;
    #1;
    check("wait_done_hi", 32'(if_wait.dwnld_done), 32'd1);
    tick();
    check("wait_done_lo", 32'(if_wait.dwnld_done), 32'd0);
    check("wait_on_arm",  32'(if_wait.dump_on), 32'd0);
    tick();
    check("wait_start", 32'(if_wait.dump_start), 32'd1);
    fall3();
    check("wait_cnt_f8", if_wait.frame_cnt, 32'd1);
    rest();
    dl_w = 1'b1;
    tick();
    check("wait_restart_stop", 32'(if_wait.dump_stop), 32'd1);
    check("wait_restart_cnt",  if_wait.frame_cnt, 32'd0);
    check("wait_restart_on",   32'(if_wait.dump_on), 32'd0);

    force u_def.frame_q = 32'hFFFF_FFFE;
    tick();
    release u_def.frame_q;
    check("wrap_preload", if_def.frame_cnt, 32'hFFFF_FFFE);
    fall3();
    check("wrap_ffffffff", if_def.frame_cnt, 32'hFFFF_FFFF);
    rest();
    fall3();
    check("wrap_zero", if_def.frame_cnt, 32'd0);
    rest();
    fall3();
    check("wrap_one", if_def.frame_cnt, 32'd1);
    check("wrap_on",  32'(if_def.dump_on), 32'd1);
    rest();

    rst_n = 1'b0;
    tick();
    check("mid_rst_on",    32'(if_def.dump_on), 32'd0);
    check("mid_rst_stop",  32'(if_def.dump_stop), 32'd0);
    check("mid_rst_start", 32'(if_def.dump_start), 32'd0);
    check("mid_rst_cnt",   if_def.frame_cnt, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rearm_on_e1", 32'(if_def.dump_on), 32'd0);
    tick();
    check("rearm_start", 32'(if_def.dump_start), 32'd1);
    check("rearm_on",    32'(if_def.dump_on), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
